// File: rtl/gates_sweep_ctrl.sv
// gates_sweep_ctrl: drives all 32 a..e vectors with a programmable hold and captures y into a truth table
module gates_sweep_ctrl #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  input  logic        y,
  output logic        busy,
  output logic        done,
  output logic [4:0]  vec_idx,
  output logic [31:0] truth_table,
  output logic [5:0]  ones_count
);
  typedef enum logic {IDLE, DRIVE} state_t;
  state_t      state, state_n;
  logic [7:0]  hcnt, hcnt_n;
  logic [4:0]  vec_n;
  logic [31:0] tt_n;
  logic [5:0]  oc_n;
  logic        done_n;
  logic        sample;
  assign sample = hcnt == 8'(HOLD_CYCLES - 1);
  // stimulus is only a function of registered state, so a..e stay glitch-free
  assign busy = state == DRIVE;
  assign {a, b, c, d, e} = busy ? vec_idx : 5'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      hcnt        <= '0;
      vec_idx     <= '0;
      truth_table <= '0;
      ones_count  <= '0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      hcnt        <= hcnt_n;
      vec_idx     <= vec_n;
      truth_table <= tt_n;
      ones_count  <= oc_n;
      done        <= done_n;
    end
  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    vec_n   = vec_idx;
    tt_n    = truth_table;
    oc_n    = ones_count;
    done_n  = 1'b0;
    if (state == IDLE) begin
      if (start) begin
        state_n = DRIVE;
        hcnt_n  = '0;
        vec_n   = '0;
        tt_n    = '0;
        oc_n    = '0;
      end
    end else if (abort) begin
      state_n = IDLE;
    end else if (!sample) begin
      hcnt_n = hcnt + 8'd1;
    end else begin
      tt_n[vec_idx] = y;
      oc_n          = ones_count + 6'(y);
      hcnt_n        = '0;
      if (vec_idx == 5'd31) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end else begin
        vec_n = vec_idx + 5'd1;
      end
    end
  end
endmodule
